// File: rtl/calc_input_sequencer_if.sv
// Button inputs and control outputs of the calculator input sequencer.
// master drives the buttons and observes the controls; slave is the sequencer.
interface calc_input_sequencer_if;
  localparam int unsigned STATE_W = 3;

  logic               Enter;
  logic               Undo;
  logic               LoadOpA;
  logic               LoadOpB;
  logic               LoadOpCode;
  logic               ToDisplaySel;
  logic [STATE_W-1:0] CurrentState;

  modport master (
    output Enter, Undo,
    input  LoadOpA, LoadOpB, LoadOpCode, ToDisplaySel, CurrentState
  );

  modport slave (
    input  Enter, Undo,
    output LoadOpA, LoadOpB, LoadOpCode, ToDisplaySel, CurrentState
  );
endinterface

// File: rtl/calc_input_sequencer.sv
// Turns Enter/Undo push-buttons into the A -> B -> opcode -> result entry sequence,
// producing one-cycle load strobes and the display-mux select.
module calc_input_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESULT_HOLD = 0
) (
  input logic                   clk,
  input logic                   resetN,
  calc_input_sequencer_if.slave bus
);
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 24;
  localparam bit          HOLD_EN = (RESULT_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    HOLD_EN ? CNT_W'(RESULT_HOLD - 1) : '0;

  typedef enum logic [STATE_W-1:0] {
    WAIT_A   = 3'd0,
    LOAD_A   = 3'd1,
    WAIT_B   = 3'd2,
    LOAD_B   = 3'd3,
    WAIT_OP  = 3'd4,
    LOAD_OP  = 3'd5,
    SHOW_RES = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] enter_sync_q, enter_sync_d;
  logic [SYNC_STAGES-1:0] undo_sync_q, undo_sync_d;
  logic                   enter_prev_q, enter_prev_d;
  logic                   undo_prev_q, undo_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   load_a_q, load_a_d;
  logic                   load_b_q, load_b_d;
  logic                   load_op_q, load_op_d;
  logic                   disp_sel_q, disp_sel_d;
  logic                   enter_pulse_c, undo_pulse_c;

  // Synchronizer shift and rising-edge detection
  always_comb begin
    enter_sync_d  = {enter_sync_q[SYNC_STAGES-2:0], bus.Enter};
    undo_sync_d   = {undo_sync_q[SYNC_STAGES-2:0], bus.Undo};
    enter_prev_d  = enter_sync_q[SYNC_STAGES-1];
    undo_prev_d   = undo_sync_q[SYNC_STAGES-1];
    enter_pulse_c = enter_sync_q[SYNC_STAGES-1] & ~enter_prev_q;
    undo_pulse_c  = undo_sync_q[SYNC_STAGES-1] & ~undo_prev_q;
  end

  // Next state, timeout counter and registered Moore output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_a_d   = 1'b0;
    load_b_d   = 1'b0;
    load_op_d  = 1'b0;
    disp_sel_d = 1'b0;

    case (state_q)
      WAIT_A: begin
        if (enter_pulse_c) state_d = LOAD_A;
      end
      LOAD_A:  state_d = WAIT_B;
      WAIT_B: begin
        if (undo_pulse_c)       state_d = WAIT_A;
        else if (enter_pulse_c) state_d = LOAD_B;
      end
      LOAD_B:  state_d = WAIT_OP;
      WAIT_OP: begin
        if (undo_pulse_c)       state_d = WAIT_B;
        else if (enter_pulse_c) state_d = LOAD_OP;
      end
      LOAD_OP: state_d = SHOW_RES;
      SHOW_RES: begin
        if (undo_pulse_c)                      state_d = WAIT_OP;
        else if (enter_pulse_c)                state_d = LOAD_A;
        else if (HOLD_EN && cnt_q == HOLD_LAST) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase

    // Counter restarts on entry and on any pulse seen while showing the result
    if (!HOLD_EN) begin
      cnt_d = '0;
    end else if (state_q != SHOW_RES || enter_pulse_c || undo_pulse_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    load_a_d   = (state_d == LOAD_A);
    load_b_d   = (state_d == LOAD_B);
    load_op_d  = (state_d == LOAD_OP);
    disp_sel_d = (state_d == SHOW_RES);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= WAIT_A;
      enter_sync_q <= '0;
      undo_sync_q  <= '0;
      enter_prev_q <= 1'b0;
      undo_prev_q  <= 1'b0;
      cnt_q        <= '0;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      load_op_q    <= 1'b0;
      disp_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enter_sync_q <= enter_sync_d;
      undo_sync_q  <= undo_sync_d;
      enter_prev_q <= enter_prev_d;
      undo_prev_q  <= undo_prev_d;
      cnt_q        <= cnt_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      load_op_q    <= load_op_d;
      disp_sel_q   <= disp_sel_d;
    end
  end

  assign bus.LoadOpA      = load_a_q;
  assign bus.LoadOpB      = load_b_q;
  assign bus.LoadOpCode   = load_op_q;
  assign bus.ToDisplaySel = disp_sel_q;
  assign bus.CurrentState = state_q;

endmodule
